// File: rtl/stopwatch_core.sv
// Stopwatch/timer core: synchronised buttons, tick divider, min:sec.tenth BCD counter
// with count-up/count-down modes and lap freeze of the displayed value.
module stopwatch_core #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 10,
   parameter int unsigned MIN_MAX = 9
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_str,
   input  logic       i_stp,
   input  logic       i_lap,
   input  logic       i_clr,
   input  logic       i_mode,
   input  logic [3:0] i_preset_min,
   input  logic [2:0] i_preset_tsec,
   input  logic [3:0] i_preset_sec,
   output logic [3:0] o_one_min,
   output logic [3:0] o_ten_sec,
   output logic [3:0] o_one_sec,
   output logic [3:0] o_one_tenth,
   output logic       o_running,
   output logic       o_frozen,
   output logic       o_done,
   output logic       o_wrap
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
   localparam logic [3:0] MIN_TOP = 4'(MIN_MAX);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   typedef struct packed {
      logic [3:0] min;
      logic [3:0] tsec;
      logic [3:0] sec;
      logic [3:0] tenth;
   } bcd_t;

   // Button vector order: {clr, stp, str, lap}, highest priority first.
   logic [3:0] r_sync1, r_sync2, r_prev;
   logic [3:0] w_btn, w_edge;
   logic       w_clr_e, w_stp_e, w_str_e, w_lap_e;

   state_e     r_state, w_state_d;
   bcd_t       r_live, w_live_d, r_lap, w_lap_d, w_up, w_dn, w_preset, w_disp;
   logic [DIV_W-1:0] r_div, w_div_d;
   logic       r_frozen, w_frozen_d;
   logic       r_mode_q, w_mode_d;
   logic       r_running, r_done, r_wrap, w_wrap_d;
   logic       w_tick, w_at_max, w_live_zero, w_hit_zero;

   assign w_btn   = {i_clr, i_stp, i_str, i_lap};
   assign w_edge  = r_sync2 & ~r_prev;
   assign w_clr_e = w_edge[3];
   assign w_stp_e = w_edge[2] & ~w_edge[3];
   assign w_str_e = w_edge[1] & ~(|w_edge[3:2]);
   assign w_lap_e = w_edge[0] & ~(|w_edge[3:1]);

   assign w_tick      = (r_state == StRun) && (r_div == '0);
   assign w_live_zero = (r_live == '0);
   assign w_at_max    = (r_live == bcd_t'({MIN_TOP, 4'd5, 4'd9, 4'd9}));
   assign w_hit_zero  = w_tick && r_mode_q && (w_dn == '0);

   always_comb begin
      w_preset.min   = (i_preset_min > MIN_TOP) ? MIN_TOP : i_preset_min;
      w_preset.tsec  = (i_preset_tsec > 3'd5) ? 4'd5 : {1'b0, i_preset_tsec};
      w_preset.sec   = (i_preset_sec > 4'd9) ? 4'd9 : i_preset_sec;
      w_preset.tenth = '0;
   end

   always_comb begin
      w_up = r_live;
      if (r_live.tenth != 4'd9) begin
         w_up.tenth = r_live.tenth + 4'd1;
      end else begin
         w_up.tenth = '0;
         if (r_live.sec != 4'd9) begin
            w_up.sec = r_live.sec + 4'd1;
         end else begin
            w_up.sec = '0;
            if (r_live.tsec != 4'd5) begin
               w_up.tsec = r_live.tsec + 4'd1;
            end else begin
               w_up.tsec = '0;
               w_up.min  = (r_live.min == MIN_TOP) ? 4'd0 : r_live.min + 4'd1;
            end
         end
      end
   end

   always_comb begin
      w_dn = r_live;
      if (r_live.tenth != 4'd0) begin
         w_dn.tenth = r_live.tenth - 4'd1;
      end else begin
         w_dn.tenth = 4'd9;
         if (r_live.sec != 4'd0) begin
            w_dn.sec = r_live.sec - 4'd1;
         end else begin
            w_dn.sec = 4'd9;
            if (r_live.tsec != 4'd0) begin
               w_dn.tsec = r_live.tsec - 4'd1;
            end else begin
               w_dn.tsec = 4'd5;
               w_dn.min  = (r_live.min == 4'd0) ? MIN_TOP : r_live.min - 4'd1;
            end
         end
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_live_d   = r_live;
      w_lap_d    = r_lap;
      w_frozen_d = r_frozen;
      w_mode_d   = r_mode_q;
      w_div_d    = r_div;
      w_wrap_d   = 1'b0;

      if (r_state == StRun) begin
         w_div_d = w_tick ? DIV_LOAD : r_div - DIV_W'(1);
      end
      if (w_tick) begin
         if (r_mode_q) begin
            w_live_d = w_dn;
         end else begin
            w_live_d = w_up;
            w_wrap_d = w_at_max;
         end
      end

      case (r_state)
         StIdle: begin
            if (w_str_e) begin
               w_mode_d = i_mode;
               if (i_mode && w_live_zero) begin
                  w_state_d = StDone;
               end else begin
                  w_state_d = StRun;
                  w_div_d   = DIV_LOAD;
               end
            end
         end
         StRun: begin
            // Reaching zero outranks a coincident stop.
            if (w_hit_zero) begin
               w_state_d = StDone;
            end else if (w_stp_e) begin
               w_state_d = StPause;
            end
            if (w_lap_e) begin
               if (!r_frozen) begin
                  w_lap_d    = r_live;
                  w_frozen_d = 1'b1;
               end else begin
                  w_frozen_d = 1'b0;
               end
            end
         end
         StPause: begin
            if (w_str_e) begin
               w_state_d = StRun;
            end else if (w_lap_e) begin
               w_frozen_d = 1'b0;
            end
         end
         default: ;
      endcase

      if (w_clr_e) begin
         w_state_d  = StIdle;
         w_frozen_d = 1'b0;
         w_wrap_d   = 1'b0;
         w_live_d   = i_mode ? w_preset : '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_prev    <= '0;
         r_state   <= StIdle;
         r_live    <= '0;
         r_lap     <= '0;
         r_div     <= DIV_LOAD;
         r_frozen  <= 1'b0;
         r_mode_q  <= 1'b0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_sync1   <= w_btn;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         r_state   <= w_state_d;
         r_live    <= w_live_d;
         r_lap     <= w_lap_d;
         r_div     <= w_div_d;
         r_frozen  <= w_frozen_d;
         r_mode_q  <= w_mode_d;
         r_running <= (w_state_d == StRun);
         r_done    <= (w_state_d == StDone);
         r_wrap    <= w_wrap_d;
      end
   end

   assign w_disp      = r_frozen ? r_lap : r_live;
   assign o_one_min   = w_disp.min;
   assign o_ten_sec   = w_disp.tsec;
   assign o_one_sec   = w_disp.sec;
   assign o_one_tenth = w_disp.tenth;
   assign o_running   = r_running;
   assign o_frozen    = r_frozen;
   assign o_done      = r_done;
   assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core with DIV=10 and MIN_MAX=1; expectations are
// queued by the stimulus and compared by a negedge monitor.
module tb_stopwatch_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       str = 1'b0, stp = 1'b0, lap = 1'b0, clr = 1'b0, mode = 1'b0;
   logic [3:0] pmin = '0;
   logic [2:0] ptsec = '0;
   logic [3:0] psec = '0;
   logic [3:0] o_min, o_tsec, o_sec, o_tenth;
   logic       o_running, o_frozen, o_done, o_wrap;

   stopwatch_core #(
      .CLK_HZ (100),
      .TICK_HZ(10),
      .MIN_MAX(1)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_str        (str),
      .i_stp        (stp),
      .i_lap        (lap),
      .i_clr        (clr),
      .i_mode       (mode),
      .i_preset_min (pmin),
      .i_preset_tsec(ptsec),
      .i_preset_sec (psec),
      .o_one_min    (o_min),
      .o_ten_sec    (o_tsec),
      .o_one_sec    (o_sec),
      .o_one_tenth  (o_tenth),
      .o_running    (o_running),
      .o_frozen     (o_frozen),
      .o_done       (o_done),
      .o_wrap       (o_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [19:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Expected word: {min, tsec, sec, tenth, running, frozen, done, wrap}.
   task automatic exp_push(input string name, input int m, input int ts, input int s,
                           input int t, input bit run, input bit frz, input bit dn,
                           input bit wr);
      exp_t e;
      e.name = name;
      e.exp  = {4'(m), 4'(ts), 4'(s), 4'(t), run, frz, dn, wr};
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [19:0] act;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            act = {o_min, o_tsec, o_sec, o_tenth, o_running, o_frozen, o_done, o_wrap};
            n_checks++;
            if (act !== e.exp) begin
               n_errors++;
               $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mask {clr, stp, str, lap}; the action lands on the 3rd rising edge.
   task automatic press(input logic [3:0] m);
      {clr, stp, str, lap} = m;
      cyc(3);
      {clr, stp, str, lap} = 4'b0000;
      cyc(2);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, required finish");
      $fatal(1);
   end

   initial begin : stimulus
      cyc(2);
      exp_push("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      exp_push("idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0);

      // Count up 25 ticks, pause, resume with partial divider period.
      press(4'b0010);
      cyc(248);
      exp_push("up_0_02_5", 0, 0, 2, 5, 1, 0, 0, 0);
      press(4'b0100);
      exp_push("paused", 0, 0, 2, 5, 0, 0, 0, 0);
      cyc(100);
      exp_push("pause_hold", 0, 0, 2, 5, 0, 0, 0, 0);
      press(4'b0010);
      cyc(4);
      exp_push("resume_partial", 0, 0, 2, 5, 1, 0, 0, 0);
      cyc(1);
      exp_push("resume_tick", 0, 0, 2, 6, 1, 0, 0, 0);

      // Lap freeze and release.
      press(4'b0001);
      exp_push("lap_freeze", 0, 0, 2, 6, 1, 1, 0, 0);
      cyc(10);
      exp_push("lap_hold", 0, 0, 2, 6, 1, 1, 0, 0);
      press(4'b0001);
      exp_push("lap_release", 0, 0, 2, 8, 1, 0, 0, 0);

      // clr lands on the same edge as a tick.
      cyc(7);
      press(4'b1000);
      exp_push("clr_on_tick", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(10);
      exp_push("idle_no_count", 0, 0, 0, 0, 0, 0, 0, 0);

      // Up-count wrap at 1:59.9.
      press(4'b0010);
      cyc(11988);
      exp_push("pre_wrap", 1, 5, 9, 9, 1, 0, 0, 0);
      cyc(10);
      exp_push("wrap_pulse", 0, 0, 0, 0, 1, 0, 0, 1);
      cyc(1);
      exp_push("wrap_one_cycle", 0, 0, 0, 0, 1, 0, 0, 0);

      // str and stp together in PAUSE.
      press(4'b0100);
      exp_push("pause_at_zero", 0, 0, 0, 0, 0, 0, 0, 0);
      press(4'b0110);
      exp_push("str_stp_pause", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(20);
      exp_push("still_paused", 0, 0, 0, 0, 0, 0, 0, 0);

      // Count down from preset 0:02.0.
      mode = 1'b1;
      pmin = 4'd0;
      ptsec = 3'd0;
      psec = 4'd2;
      press(4'b1000);
      exp_push("down_load", 0, 0, 2, 0, 0, 0, 0, 0);
      press(4'b0010);
      cyc(10);
      exp_push("down_0_01_9", 0, 0, 1, 9, 1, 0, 0, 0);
      cyc(187);
      exp_push("down_0_00_1", 0, 0, 0, 1, 1, 0, 0, 0);
      cyc(1);
      exp_push("down_done", 0, 0, 0, 0, 0, 0, 1, 0);
      press(4'b0010);
      exp_push("done_ignores_str", 0, 0, 0, 0, 0, 0, 1, 0);
      press(4'b0100);
      exp_push("done_ignores_stp", 0, 0, 0, 0, 0, 0, 1, 0);
      press(4'b1000);
      exp_push("done_clr", 0, 0, 2, 0, 0, 0, 0, 0);

      // Preset clamping and zero preset.
      pmin = 4'd4;
      ptsec = 3'd7;
      psec = 4'd3;
      press(4'b1000);
      exp_push("clamp_min_tsec", 1, 5, 3, 0, 0, 0, 0, 0);
      pmin = 4'd0;
      ptsec = 3'd2;
      psec = 4'd12;
      press(4'b1000);
      exp_push("clamp_sec", 0, 2, 9, 0, 0, 0, 0, 0);
      ptsec = 3'd0;
      psec = 4'd0;
      press(4'b1000);
      exp_push("preset_zero", 0, 0, 0, 0, 0, 0, 0, 0);
      press(4'b0010);
      exp_push("zero_start_done", 0, 0, 0, 0, 0, 0, 1, 0);

      // Asynchronous reset in the middle of a run.
      mode = 1'b0;
      press(4'b1000);
      exp_push("up_clr", 0, 0, 0, 0, 0, 0, 0, 0);
      press(4'b0010);
      cyc(338);
      exp_push("pre_reset", 0, 0, 3, 4, 1, 0, 0, 0);
      cyc(1);
      #1;
      rst_n = 1'b0;
      exp_push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      exp_push("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
      press(4'b0010);
      cyc(8);
      exp_push("restart_from_zero", 0, 0, 0, 1, 1, 0, 0, 0);

      cyc(3);
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
